// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with row synchronizer, debounce and a valid/ready key event output.
// Optional auto-repeat while a key is held is built when KEYSCAN_TYPEMATIC_EN is defined.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV       = 16,
  parameter int DEBOUNCE       = 4,
  parameter int REPEAT_SAMPLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] r,
  output logic [3:0] c,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [3:0] key_code,
  output logic       overrun
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [1:0] SCAN    = 2'd0;
  localparam logic [1:0] CONFIRM = 2'd1;
  localparam logic [1:0] HELD    = 2'd2;

  generate
    if (SCAN_DIV < 4 || DEBOUNCE < 1 || DEBOUNCE > 15 || REPEAT_SAMPLES < 1) begin : g_bad_param
      $error("keypad_scan_ctrl: parameter out of legal range");
    end
  endgenerate

  // Reset asserts asynchronously but its release is retimed to clk.
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_reg <= 2'b00;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n = rst_sync_reg[1];

  logic [3:0]    r_meta_reg, r_sync_reg;
  logic [DW-1:0] dwell_reg, dwell_next;
  logic [1:0]    state_reg, state_next;
  logic [1:0]    col_reg, col_next;
  logic [1:0]    row_reg, row_next;
  logic [3:0]    match_reg, match_next;
  logic [3:0]    rel_reg, rel_next;
  logic          key_valid_reg, key_valid_next;
  logic [3:0]    key_code_reg, key_code_next;
  logic          overrun_reg, overrun_next;
  logic          sample;
  logic          row_hit;
  logic          emit;
  logic [1:0]    low_row;

`ifdef KEYSCAN_TYPEMATIC_EN
  localparam int RW = $clog2(REPEAT_SAMPLES) + 1;
  logic [RW-1:0] rep_reg, rep_next;
`endif

  assign sample  = (dwell_reg == DW'(SCAN_DIV - 1));
  assign row_hit = r_sync_reg[row_reg];

  always_comb begin
    low_row = 2'd3;
    if (r_sync_reg[0])      low_row = 2'd0;
    else if (r_sync_reg[1]) low_row = 2'd1;
    else if (r_sync_reg[2]) low_row = 2'd2;
  end

  always_comb begin
    dwell_next = sample ? '0 : dwell_reg + 1'b1;
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    match_next = match_reg;
    rel_next   = rel_reg;
    emit       = 1'b0;
`ifdef KEYSCAN_TYPEMATIC_EN
    rep_next   = rep_reg;
`endif
    if (sample) begin
      case (state_reg)
        SCAN: begin
          if (r_sync_reg != 4'b0000) begin
            row_next   = low_row;
            match_next = 4'd0;
            state_next = CONFIRM;
          end else begin
            col_next = col_reg + 2'd1;
          end
        end
        CONFIRM: begin
          if (row_hit) begin
            if (match_reg == 4'(DEBOUNCE - 1)) begin
              emit       = 1'b1;
              match_next = 4'd0;
              rel_next   = 4'd0;
              state_next = HELD;
            end else begin
              match_next = match_reg + 4'd1;
            end
          end else begin
            match_next = 4'd0;
            state_next = SCAN;
            col_next   = col_reg + 2'd1;
          end
        end
        HELD: begin
          if (!row_hit) begin
            if (rel_reg == 4'(DEBOUNCE - 1)) begin
              rel_next   = 4'd0;
              state_next = SCAN;
              col_next   = col_reg + 2'd1;
`ifdef KEYSCAN_TYPEMATIC_EN
              rep_next   = '0;
`endif
            end else begin
              rel_next = rel_reg + 4'd1;
            end
          end else begin
            rel_next = 4'd0;
`ifdef KEYSCAN_TYPEMATIC_EN
            if (rep_reg == RW'(REPEAT_SAMPLES - 1)) begin
              emit     = 1'b1;
              rep_next = '0;
            end else begin
              rep_next = rep_reg + 1'b1;
            end
`endif
          end
        end
        default: begin
          state_next = SCAN;
        end
      endcase
    end
  end

  // A new event only displaces the held one if the consumer takes it this cycle.
  always_comb begin
    key_valid_next = key_valid_reg;
    key_code_next  = key_code_reg;
    overrun_next   = 1'b0;
    if (emit) begin
      if (!key_valid_reg || key_ready) begin
        key_valid_next = 1'b1;
        key_code_next  = {row_reg, col_reg};
      end else begin
        overrun_next = 1'b1;
      end
    end else if (key_valid_reg && key_ready) begin
      key_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta_reg    <= 4'b0000;
      r_sync_reg    <= 4'b0000;
      dwell_reg     <= '0;
      state_reg     <= SCAN;
      col_reg       <= 2'd0;
      row_reg       <= 2'd0;
      match_reg     <= 4'd0;
      rel_reg       <= 4'd0;
      key_valid_reg <= 1'b0;
      key_code_reg  <= 4'd0;
      overrun_reg   <= 1'b0;
`ifdef KEYSCAN_TYPEMATIC_EN
      rep_reg       <= '0;
`endif
    end else begin
      r_meta_reg    <= r;
      r_sync_reg    <= r_meta_reg;
      dwell_reg     <= dwell_next;
      state_reg     <= state_next;
      col_reg       <= col_next;
      row_reg       <= row_next;
      match_reg     <= match_next;
      rel_reg       <= rel_next;
      key_valid_reg <= key_valid_next;
      key_code_reg  <= key_code_next;
      overrun_reg   <= overrun_next;
`ifdef KEYSCAN_TYPEMATIC_EN
      rep_reg       <= rep_next;
`endif
    end
  end

  assign c         = 4'b0001 << col_reg;
  assign key_valid = key_valid_reg;
  assign key_code  = key_code_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: a keypad model answers the column drive,
// expected key codes are queued by the stimulus and popped by a handshake monitor.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] r;
  logic [3:0] c;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] key_code;
  logic       overrun;

  logic       pressed;
  logic [1:0] prow, pcol;

  int checks = 0;
  int errors = 0;
  int ev_cnt = 0;
  int ovr_cnt = 0;
  int exp_q[$];

  keypad_scan_ctrl #(.SCAN_DIV(16), .DEBOUNCE(4), .REPEAT_SAMPLES(64)) dut (
    .clk(clk), .reset(reset), .r(r), .c(c),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Single-key matrix: the pressed row reads high only while its column is driven.
  always_comb begin
    r = 4'b0000;
    if (pressed && c[pcol]) r[prow] = 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  always @(negedge clk) begin
    if (reset && overrun) ovr_cnt++;
    if (reset && key_valid && key_ready) begin
      ev_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got code %0d expected none", key_code);
      end else begin
        check("event_code", int'(key_code), exp_q.pop_front());
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int row, input int col, input int hold, input int gap);
    prow = 2'(row);
    pcol = 2'(col);
    pressed = 1'b1;
    cycles(hold);
    pressed = 1'b0;
    cycles(gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ev0, ov0;
    logic [3:0] prev;
    reset = 1'b0;
    key_ready = 1'b1;
    pressed = 1'b0;
    prow = 2'd0;
    pcol = 2'd0;
    cycles(3);
    check("reset_c", int'(c), 1);
    check("reset_valid", int'(key_valid), 0);
    check("reset_code", int'(key_code), 0);
    check("reset_overrun", int'(overrun), 0);
    reset = 1'b1;
    cycles(5);

    // Clean press: row 2, column 1 -> code 9, column frozen while held.
    ev0 = ev_cnt;
    exp_q.push_back(9);
    prow = 2'd2; pcol = 2'd1; pressed = 1'b1;
    cycles(200);
    check("clean_c_frozen", int'(c), 2);
    cycles(50);
    pressed = 1'b0;
    cycles(150);
    check("clean_events", ev_cnt - ev0, 1);

    // Full sweep: codes 0..15 in order, no overrun.
    ev0 = ev_cnt; ov0 = ovr_cnt;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        exp_q.push_back(4 * i + j);
        press(i, j, 250, 150);
      end
    check("sweep_events", ev_cnt - ev0, 16);
    check("sweep_overrun", ovr_cnt - ov0, 0);

    // Bounce on row 3 col 0, phased so every sample lands in an off half-period.
    prev = c;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (prev == 4'b1000 && c == 4'b0001) break;
      prev = c;
    end
    ev0 = ev_cnt;
    prow = 2'd3; pcol = 2'd0; pressed = 1'b1;
    for (int m = 1; m <= 12; m++) begin
      cycles(8);
      pressed = ~pressed;
    end
    check("bounce_no_event", ev_cnt - ev0, 0);
    exp_q.push_back(12);
    cycles(250);
    pressed = 1'b0;
    cycles(150);
    check("bounce_events", ev_cnt - ev0, 1);

    // Backpressure: code 5 held, code 10 dropped with one overrun pulse.
    key_ready = 1'b0;
    ov0 = ovr_cnt;
    press(1, 1, 250, 150);
    press(2, 2, 250, 150);
    check("bp_valid", int'(key_valid), 1);
    check("bp_code", int'(key_code), 5);
    check("bp_overrun", ovr_cnt - ov0, 1);
    exp_q.push_back(5);
    key_ready = 1'b1;
    cycles(1);
    key_ready = 1'b0;
    @(negedge clk);
    check("bp_valid_after", int'(key_valid), 0);
    cycles(2);

    // Reset while a key is held with an unaccepted event.
    prow = 2'd1; pcol = 2'd2; pressed = 1'b1;
    cycles(250);
    check("rst_pre_valid", int'(key_valid), 1);
    #3 reset = 1'b0;
    #1;
    check("rst_c", int'(c), 1);
    check("rst_valid", int'(key_valid), 0);
    cycles(3);
    reset = 1'b1;
    key_ready = 1'b1;
    ev0 = ev_cnt;
    exp_q.push_back(6);
    cycles(300);
    pressed = 1'b0;
    cycles(150);
    check("rst_redetect", ev_cnt - ev0, 1);

`ifdef KEYSCAN_TYPEMATIC_EN
    ev0 = ev_cnt;
    for (int k = 0; k < 4; k++) exp_q.push_back(3);
    press(0, 3, 210 * 16, 150);
    check("typematic_events", ev_cnt - ev0, 4);
`endif

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
